// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receive datapath.
package i2c_pkg;

   localparam int unsigned BITS_PER_BYTE = 8;

   typedef enum logic [1:0] {
      IDLE,
      RX_BITS,
      ACK
   } rx_state_t;

endpackage

// File: rtl/i2c_if.sv
// Bus-side and consumer-side signals of the I2C receive datapath.
interface i2c_if #(
   parameter int unsigned NUM_BYTES = 6
) ();

   logic                          SCL;
   logic                          SCL_prev;
   logic                          SDA;
   logic                          SDA_prev;
   logic                          enable;
   logic                          done;
   logic                          SDA_down;
   logic [NUM_BYTES-1:0][3:0]     HEX_out;

   // Environment side: drives the sampled bus and enable, observes results
   modport master (
      output SCL, SCL_prev, SDA, SDA_prev, enable,
      input  done, SDA_down, HEX_out
   );

   // Receiver side
   modport slave (
      input  SCL, SCL_prev, SDA, SDA_prev, enable,
      output done, SDA_down, HEX_out
   );

endinterface

// File: rtl/i2c_bus_cond_detect.sv
// Decodes SCL edges and START/STOP conditions from current and one-cycle-old bus samples.
module i2c_bus_cond_detect (
   input  logic i_scl,
   input  logic i_scl_prev,
   input  logic i_sda,
   input  logic i_sda_prev,
   input  logic i_enable,
   output logic o_scl_rise_c,
   output logic o_scl_fall_c,
   output logic o_start_c,
   output logic o_stop_c
);

   logic w_scl_high;

   // SCL held high across both samples: the window where SDA edges are START/STOP
   assign w_scl_high   = i_scl & i_scl_prev;

   assign o_scl_rise_c = i_enable &  i_scl & ~i_scl_prev;
   assign o_scl_fall_c = i_enable & ~i_scl &  i_scl_prev;
   assign o_start_c    = i_enable & w_scl_high & ~i_sda &  i_sda_prev;
   assign o_stop_c     = i_enable & w_scl_high &  i_sda & ~i_sda_prev;

endmodule

// File: rtl/i2c_data_in_top_level.sv
// I2C slave receiver: shifts in MSB-first bytes, ACKs them, keeps each byte's low nibble.
module i2c_data_in_top_level
   import i2c_pkg::*;
#(
   parameter int unsigned NUM_BYTES = 6
) (
   input  logic   FPGA_clk,
   input  logic   rst,
   i2c_if.slave   bus
);

   localparam int unsigned IDX_W = $clog2(NUM_BYTES + 1);
   localparam int unsigned CNT_W = $clog2(BITS_PER_BYTE);

   rx_state_t                     r_state,     w_state_nxt;
   logic [CNT_W-1:0]              r_bit_cnt,   w_bit_cnt_nxt;
   logic [BITS_PER_BYTE-1:0]      r_shift,     w_shift_nxt;
   logic [IDX_W-1:0]              r_byte_idx,  w_byte_idx_nxt;
   logic                          r_ack_hi,    w_ack_hi_nxt;
   logic                          r_done,      w_done_nxt;
   logic                          r_sda_down,  w_sda_down_nxt;
   logic [NUM_BYTES-1:0][3:0]     r_hex,       w_hex_nxt;

   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;
   logic w_room;

   i2c_bus_cond_detect u_cond (
      .i_scl        (bus.SCL),
      .i_scl_prev   (bus.SCL_prev),
      .i_sda        (bus.SDA),
      .i_sda_prev   (bus.SDA_prev),
      .i_enable     (bus.enable),
      .o_scl_rise_c (w_scl_rise),
      .o_scl_fall_c (w_scl_fall),
      .o_start_c    (w_start),
      .o_stop_c     (w_stop)
   );

   // A byte slot is still free; once full, bytes are NACKed and dropped
   assign w_room = (r_byte_idx < IDX_W'(NUM_BYTES));

   // Next-state and next-output logic; everything holds unless an event fires
   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_byte_idx_nxt = r_byte_idx;
      w_ack_hi_nxt   = r_ack_hi;
      w_done_nxt     = r_done;
      w_sda_down_nxt = r_sda_down;
      w_hex_nxt      = r_hex;

      if (!bus.enable) begin
         w_state_nxt = r_state;
      end else if (w_start) begin
         w_state_nxt    = RX_BITS;
         w_bit_cnt_nxt  = '0;
         w_byte_idx_nxt = '0;
         w_ack_hi_nxt   = 1'b0;
         w_done_nxt     = 1'b0;
         w_sda_down_nxt = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = RX_BITS;
            end
            RX_BITS: begin
               if (w_stop) begin
                  w_bit_cnt_nxt = '0;
                  w_shift_nxt   = '0;
               end else if (w_scl_rise) begin
                  w_shift_nxt   = {r_shift[BITS_PER_BYTE-2:0], bus.SDA};
                  w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                  if (r_bit_cnt == CNT_W'(BITS_PER_BYTE - 1)) begin
                     if (w_room) begin
                        w_hex_nxt[r_byte_idx] = {r_shift[2:0], bus.SDA};
                     end
                     w_ack_hi_nxt = 1'b0;
                     w_state_nxt  = ACK;
                  end
               end
            end
            ACK: begin
               // STOP here is the master releasing SDA after the 9th clock; ignored
               if (w_scl_rise) begin
                  w_ack_hi_nxt = 1'b1;
               end else if (w_scl_fall) begin
                  if (!r_ack_hi) begin
                     w_sda_down_nxt = w_room;
                  end else begin
                     w_sda_down_nxt = 1'b0;
                     w_bit_cnt_nxt  = '0;
                     w_ack_hi_nxt   = 1'b0;
                     w_state_nxt    = RX_BITS;
                     if (w_room) begin
                        w_byte_idx_nxt = r_byte_idx + IDX_W'(1);
                        if (r_byte_idx == IDX_W'(NUM_BYTES - 1)) begin
                           w_done_nxt = 1'b1;
                        end
                     end
                  end
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge FPGA_clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_byte_idx <= '0;
         r_ack_hi   <= 1'b0;
         r_done     <= 1'b0;
         r_sda_down <= 1'b0;
         r_hex      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_byte_idx <= w_byte_idx_nxt;
         r_ack_hi   <= w_ack_hi_nxt;
         r_done     <= w_done_nxt;
         r_sda_down <= w_sda_down_nxt;
         r_hex      <= w_hex_nxt;
      end
   end

   assign bus.done     = r_done;
   assign bus.SDA_down = r_sda_down;
   assign bus.HEX_out  = r_hex;

endmodule

// File: tb/tb_i2c_data_in_top_level.sv
// Self-checking bench: open-drain bus model, transaction-level reference, directed + random traffic.
module tb_i2c_data_in_top_level;

   localparam int unsigned NB = 6;

   logic clk = 1'b0;
   logic rst;
   logic sda_m;

   int errs   = 0;
   int checks = 0;

   // Reference model: what the receiver should hold, at transfer level
   logic [3:0] m_hex [NB];
   int         m_idx;
   bit         m_done;

   always #5 clk = ~clk;

   i2c_if #(.NUM_BYTES(NB)) bus ();

   i2c_data_in_top_level #(.NUM_BYTES(NB)) dut (
      .FPGA_clk (clk),
      .rst      (rst),
      .bus      (bus)
   );

   // Open-drain line: master releases or pulls, slave can only pull low
   assign bus.SDA = sda_m & ~bus.SDA_down;

   // One-clock-delayed bus samples
   always @(posedge clk) begin
      bus.SCL_prev <= bus.SCL;
      bus.SDA_prev <= bus.SDA;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) m_hex[i] = 4'h0;
      m_idx  = 0;
      m_done = 0;
   endtask

   task automatic chk_hex(input string tag);
      for (int i = 0; i < NB; i++) chk($sformatf("%s_hex%0d", tag, i), 32'(bus.HEX_out[i]), 32'(m_hex[i]));
   endtask

   // One data clock: SDA set while SCL low, SCL high for two FPGA clocks
   task automatic send_bit(input logic b);
      @(negedge clk) sda_m = b;
      @(negedge clk) bus.SCL = 1'b1;
      @(negedge clk) chk("sda_down_data", 32'(bus.SDA_down), 32'h0);
      @(negedge clk) bus.SCL = 1'b0;
   endtask

   // Byte already clocked in: check storage, then run the 9th clock with master releasing SDA while SCL high
   task automatic ack_phase(input logic [7:0] b);
      bit ack;
      ack = (m_idx < NB);
      if (ack) m_hex[m_idx] = b[3:0];
      chk_hex("byte");
      @(negedge clk) begin
         chk("sda_down_ack_lo", 32'(bus.SDA_down), 32'(ack));
         sda_m = 1'b0;
      end
      @(negedge clk) bus.SCL = 1'b1;
      @(negedge clk) begin
         chk("sda_down_ack_hi", 32'(bus.SDA_down), 32'(ack));
         sda_m = 1'b1;
      end
      @(negedge clk) begin
         chk("sda_down_ack_hi2", 32'(bus.SDA_down), 32'(ack));
         bus.SCL = 1'b0;
      end
      if (ack) begin
         m_idx++;
         if (m_idx == NB) m_done = 1;
      end
      @(negedge clk) begin
         chk("sda_down_release", 32'(bus.SDA_down), 32'h0);
         chk("done", 32'(bus.done), 32'(m_done));
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      ack_phase(b);
   endtask

   // START from idle bus or repeated START from mid-transfer
   task automatic do_start();
      if (bus.SCL) begin
         @(negedge clk) sda_m = 1'b0;
         @(negedge clk);
         @(negedge clk) bus.SCL = 1'b0;
      end else begin
         @(negedge clk) sda_m = 1'b1;
         @(negedge clk) bus.SCL = 1'b1;
         @(negedge clk) sda_m = 1'b0;
         @(negedge clk) bus.SCL = 1'b0;
      end
      m_idx  = 0;
      m_done = 0;
      @(negedge clk) chk("done_after_start", 32'(bus.done), 32'h0);
   endtask

   // n data bits then STOP: the partial byte is discarded
   task automatic partial_stop(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
      @(negedge clk) sda_m = 1'b0;
      @(negedge clk) bus.SCL = 1'b1;
      @(negedge clk) sda_m = 1'b1;
      @(negedge clk) bus.SCL = 1'b0;
      @(negedge clk) chk("done_after_stop", 32'(bus.done), 32'(m_done));
      chk_hex("stop");
   endtask

   // Byte interrupted by `k` SCL periods with enable low; those bits must not land
   task automatic paused_byte(input logic [7:0] b, input int split, input int k);
      for (int i = 7; i > 7 - split; i--) send_bit(b[i]);
      @(negedge clk) bus.enable = 1'b0;
      for (int j = 0; j < k; j++) send_bit(1'($urandom_range(0, 1)));
      @(negedge clk) bus.enable = 1'b1;
      for (int i = 7 - split; i >= 0; i--) send_bit(b[i]);
      ack_phase(b);
   endtask

   initial begin
      logic [7:0] seq [6];
      seq = '{8'h49, 8'hAA, 8'h92, 8'hAA, 8'h24, 8'hAA};

      rst        = 1'b0;
      bus.SCL    = 1'b1;
      sda_m      = 1'b1;
      bus.enable = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_sda_down", 32'(bus.SDA_down), 32'h0);
      chk_hex("rst");
      rst = 1'b1;
      @(negedge clk) bus.enable = 1'b1;
      @(negedge clk);

      // Six bytes fill the display, then a seventh must be NACKed
      do_start();
      foreach (seq[i]) send_byte(seq[i]);
      chk("done_full", 32'(bus.done), 32'h1);
      send_byte(8'hE7);

      // STOP mid-byte, then a full byte lands in the same slot
      do_start();
      send_byte(8'h71);
      partial_stop(8'hFF, 3);
      send_byte(8'h5C);

      // Enable low for four SCL periods mid-byte
      paused_byte(8'hB6, 3, 4);

      // Repeated START rewinds the slot index
      do_start();
      send_byte(8'h10);
      send_byte(8'h20);
      do_start();
      send_byte(8'h3F);
      chk("done_after_restart", 32'(bus.done), 32'h0);

      // Asynchronous reset in the middle of a byte, away from any clock edge
      send_bit(1'b1);
      send_bit(1'b0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("async_rst_done", 32'(bus.done), 32'h0);
      chk("async_rst_sda_down", 32'(bus.SDA_down), 32'h0);
      chk_hex("async_rst");
      @(negedge clk) rst = 1'b1;
      do_start();

      // Random mix of bytes, STOP-aborted partials, enable pauses and repeated STARTs
      for (int n = 0; n < 40; n++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op == 0)      do_start();
         else if (op == 1) partial_stop(8'($urandom), int'($urandom_range(1, 7)));
         else if (op == 2) paused_byte(8'($urandom), int'($urandom_range(1, 7)), int'($urandom_range(1, 4)));
         else              send_byte(8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
